ddr4_cmd_decoder: RTL
=====================

// Module: ddr4_cmd_decoder
// PURPOSE
//  DIMM-side receiver for the DDR4 command/address bus driven by the host (act_n, A, bg, ba, cs_n).
//  Decodes each bus cycle into a typed command and tracks per-bank open/closed state and open row.
//  Checks tRCD/tRP/tRAS/tRFC spacing with per-bank counters and flags protocol/timing violations.
//  Sits between the DIMM pins and the per-chip bank FSMs; also serves as a bus-compliance monitor.
// PARAMETERS
//  BGWIDTH 2 bank-group address bits | BAWIDTH 2 bank address bits | ADDRWIDTH 17 A width
//  COLWIDTH 10 column bits | TWIDTH 8 timer counter width
//  T_RCD 17 | T_RP 17 | T_RAS 32 | T_RFC 34 | T_WR 14 | T_RTP 7 (all in ck_tp cycles, >=1)
//  PARITY_EN 0 1 = check even C/A parity
// PORTS
//  ck_tp      in   1          clock; all state updates on posedge
//  reset      in   1          asynchronous, active-high reset
//  cke        in   1          0 = bus ignored (treated as DES), timers keep counting
//  cs_n       in   1          0 = command cycle
//  act_n      in   1          0 = ACT
//  A          in   ADDRWIDTH  row (ACT) / A16..A14 = RAS_n,CAS_n,WE_n, A10 = AP/all, A[COLWIDTH-1:0] = col
//  bg         in   BGWIDTH    bank group
//  ba         in   BAWIDTH    bank
//  parity     in   1          C/A parity bit
//  cmd_valid  out  1          decoded command present (1-cycle pulse)
//  cmd        out  cmd_t      ACT/RD/RDA/WR/WRA/PRE/PREA/REF/MRS/ZQC
//  cmd_bg     out  BGWIDTH    | cmd_ba out BAWIDTH | cmd_row out ADDRWIDTH | cmd_col out COLWIDTH
//  bank_open  out  2**(BGWIDTH+BAWIDTH)  per-bank open flag, index {bg,ba}
//  err_state  out  1          illegal command for bank state (pulse, with cmd_valid)
//  err_timing out  1          timing violation (pulse, with cmd_valid)
//  err_parity out  1          parity mismatch (pulse; cmd_valid stays 0)
//  err_sticky out  1          OR of all errors since reset
// BEHAVIOUR
//  - Reset: all outputs 0, all banks closed, all counters 0, err_sticky 0. Reset mid-burst aborts everything.
//  - Latency: command sampled at posedge N appears on outputs at N+1 (registered), held for 1 cycle.
//  - Decode (cs_n=0, cke=1): act_n=0 -> ACT, row=A. Otherwise {A16,A15,A14}: 101 RD(A10?RDA), 100 WR(A10?WRA),
//    010 PRE(A10?PREA), 001 REF, 000 MRS, 110 ZQC, 111 NOP. cs_n=1, cke=0 or NOP: cmd_valid=0.
//  - Parity (PARITY_EN=1): ^{act_n,A,bg,ba,parity} != 0 -> command discarded, err_parity pulse.
//  - Per bank: open, row, trcd_cnt, tras_cnt, trp_cnt; counters decrement to 0 and saturate; reload beats decrement.
//  - ACT: closed & trp_cnt==0 -> open, load trcd=T_RCD-1, tras=T_RAS-1. Open bank -> err_state, no update.
//    trp_cnt!=0 -> err_timing, still applied.
//  - RD/WR: closed bank -> err_state, no update; trcd_cnt!=0 -> err_timing, applied.
//  - RDA/WRA: as RD/WR then close; trp=T_RTP+T_RP-1 (RDA) / T_WR+T_RP-1 (WRA).
//  - PRE: open -> close, trp=T_RP-1; tras_cnt!=0 -> err_timing. Closed bank: legal no-op.
//  - PREA: PRE applied to every open bank; err_timing if any open bank has tras_cnt!=0.
//  - REF: any bank open -> err_state, no update; else load global trfc=T_RFC-1.
//    Any non-NOP command while trfc!=0 -> err_timing.
//  - MRS/ZQC: reported only, no state change.
//  - Only one command per cycle exists on the bus; no arbitration needed.
//  - Widths: counters TWIDTH bits; T_* + T_* must fit in TWIDTH (elaboration assert).
// STRUCTURE
//  - ddr4_cmd_pkg: cmd_t enum, RAS/CAS/WE code constants, bank index function {bg,ba}.
//  - Sub-module ddr4_bank_tracker (one per bank via generate): open flag, row, three counters;
//    inputs: decoded op + hit, outputs: open, err_state/err_timing contributions.
//  - Top: decode, parity, tRFC counter, error OR, output registers.
// TESTING
//  1. reset=1 mid-ACT then release -> all outputs 0, bank_open=0, err_sticky=0.
//  2. ACT bg0 ba1 row1; RD A=17'b10100000000000010 at +17 cycles -> cmd=RD, col=2, no errors.
//  3. ACT bg0 ba1, WR at +5 cycles -> cmd=WR, err_timing=1; WR to closed bank 2 -> err_state=1, bank stays closed.
//  4. PRE A=17'b01000000000000000 at +10 cycles after ACT -> err_timing (tRAS); at +32 -> clean, bank_open[1]=0;
//     ACT same bank at +16 after PRE -> err_timing, at +17 -> clean.
//  5. WRA then ACT at T_WR+T_RP-1 -> err_timing; at T_WR+T_RP -> clean.
//  6. REF with bank 1 open -> err_state; PREA then REF; ACT at +20 -> err_timing; at +34 -> clean.
//     PARITY_EN=1 with bad parity -> err_parity, cmd_valid=0.

Source files
------------

// File: rtl/ddr4_cmd_pkg.sv
// Shared types and constants for the DDR4 command/address bus decoder.
package ddr4_cmd_pkg;

  typedef enum logic [3:0] {
    CMD_NOP  = 4'd0,
    CMD_ACT  = 4'd1,
    CMD_RD   = 4'd2,
    CMD_RDA  = 4'd3,
    CMD_WR   = 4'd4,
    CMD_WRA  = 4'd5,
    CMD_PRE  = 4'd6,
    CMD_PREA = 4'd7,
    CMD_REF  = 4'd8,
    CMD_MRS  = 4'd9,
    CMD_ZQC  = 4'd10
  } cmd_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ACT  = 3'd1,
    OP_RW   = 3'd2,
    OP_RDA  = 3'd3,
    OP_WRA  = 3'd4,
    OP_PRE  = 3'd5
  } bank_op_t;

  // {RAS_n, CAS_n, WE_n} as carried on A16..A14
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_REF = 3'b001;
  localparam logic [2:0] RCW_MRS = 3'b000;
  localparam logic [2:0] RCW_ZQC = 3'b110;
  localparam logic [2:0] RCW_NOP = 3'b111;

  function automatic int unsigned bank_index(input int unsigned bg_v,
                                             input int unsigned ba_v,
                                             input int unsigned ba_width);
    return (bg_v << ba_width) | ba_v;
  endfunction

endpackage

// File: rtl/ddr4_bank_tracker.sv
// One DDR4 bank: open flag, open row and tRCD/tRAS/tRP countdowns, with
// state/timing error contributions for the command currently addressed to it.
module ddr4_bank_tracker
  import ddr4_cmd_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned TWIDTH    = 8,
  parameter int unsigned T_RCD     = 17,
  parameter int unsigned T_RP      = 17,
  parameter int unsigned T_RAS     = 32,
  parameter int unsigned T_WR      = 14,
  parameter int unsigned T_RTP     = 7
) (
  input  logic                 ck_tp,
  input  logic                 reset,
  input  bank_op_t             op,
  input  logic                 hit,
  input  logic [ADDRWIDTH-1:0] row_in,
  output logic                 is_open,
  output logic [ADDRWIDTH-1:0] row,
  output logic                 err_state,
  output logic                 err_timing
);

  localparam logic [TWIDTH-1:0] RCD_LD = TWIDTH'(T_RCD - 1);
  localparam logic [TWIDTH-1:0] RAS_LD = TWIDTH'(T_RAS - 1);
  localparam logic [TWIDTH-1:0] RP_LD  = TWIDTH'(T_RP - 1);
  localparam logic [TWIDTH-1:0] RDA_LD = TWIDTH'(T_RTP + T_RP - 1);
  localparam logic [TWIDTH-1:0] WRA_LD = TWIDTH'(T_WR + T_RP - 1);

  logic [TWIDTH-1:0] trcd_cnt, tras_cnt, trp_cnt;

  always_comb begin
    err_state  = 1'b0;
    err_timing = 1'b0;
    if (hit) begin
      case (op)
        OP_ACT: begin
          if (is_open)              err_state  = 1'b1;
          else if (trp_cnt != '0)   err_timing = 1'b1;
        end
        OP_RW, OP_RDA, OP_WRA: begin
          if (!is_open)             err_state  = 1'b1;
          else if (trcd_cnt != '0)  err_timing = 1'b1;
        end
        OP_PRE: begin
          if (is_open && tras_cnt != '0) err_timing = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A reload on the same edge wins over the free-running decrement.
  always_ff @(posedge ck_tp or posedge reset) begin
    if (reset) begin
      is_open  <= 1'b0;
      row      <= '0;
      trcd_cnt <= '0;
      tras_cnt <= '0;
      trp_cnt  <= '0;
    end else begin
      if (trcd_cnt != '0) trcd_cnt <= trcd_cnt - TWIDTH'(1);
      if (tras_cnt != '0) tras_cnt <= tras_cnt - TWIDTH'(1);
      if (trp_cnt  != '0) trp_cnt  <= trp_cnt  - TWIDTH'(1);
      if (hit) begin
        case (op)
          OP_ACT: if (!is_open) begin
            is_open  <= 1'b1;
            row      <= row_in;
            trcd_cnt <= RCD_LD;
            tras_cnt <= RAS_LD;
          end
          OP_RDA: if (is_open) begin
            is_open <= 1'b0;
            trp_cnt <= RDA_LD;
          end
          OP_WRA: if (is_open) begin
            is_open <= 1'b0;
            trp_cnt <= WRA_LD;
          end
          OP_PRE: if (is_open) begin
            is_open <= 1'b0;
            trp_cnt <= RP_LD;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// DIMM-side DDR4 C/A bus receiver: decodes bus cycles into typed commands,
// tracks per-bank state and flags protocol, timing and parity errors.
module ddr4_cmd_decoder
  import ddr4_cmd_pkg::*;
#(
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned COLWIDTH  = 10,
  parameter int unsigned TWIDTH    = 8,
  parameter int unsigned T_RCD     = 17,
  parameter int unsigned T_RP      = 17,
  parameter int unsigned T_RAS     = 32,
  parameter int unsigned T_RFC     = 34,
  parameter int unsigned T_WR      = 14,
  parameter int unsigned T_RTP     = 7,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic                              ck_tp,
  input  logic                              reset,
  input  logic                              cke,
  input  logic                              cs_n,
  input  logic                              act_n,
  input  logic [ADDRWIDTH-1:0]              A,
  input  logic [BGWIDTH-1:0]                bg,
  input  logic [BAWIDTH-1:0]                ba,
  input  logic                              parity,
  output logic                              cmd_valid,
  output cmd_t                              cmd,
  output logic [BGWIDTH-1:0]                cmd_bg,
  output logic [BAWIDTH-1:0]                cmd_ba,
  output logic [ADDRWIDTH-1:0]              cmd_row,
  output logic [COLWIDTH-1:0]               cmd_col,
  output logic [2**(BGWIDTH+BAWIDTH)-1:0]   bank_open,
  output logic                              err_state,
  output logic                              err_timing,
  output logic                              err_parity,
  output logic                              err_sticky
);

  localparam int unsigned IDXW  = BGWIDTH + BAWIDTH;
  localparam int unsigned NBANK = 1 << IDXW;
  localparam int unsigned TMAX  = 1 << TWIDTH;
  localparam logic [TWIDTH-1:0] RFC_LD = TWIDTH'(T_RFC - 1);

  if (T_RCD < 1 || T_RP < 1 || T_RAS < 1 || T_RFC < 1 || T_WR < 1 || T_RTP < 1 ||
      T_RCD > TMAX || T_RAS > TMAX || T_RFC > TMAX ||
      T_WR + T_RP > TMAX || T_RTP + T_RP > TMAX) begin : g_bad_timing
    $fatal(1, "ddr4_cmd_decoder: timing parameters do not fit TWIDTH counters");
  end

  cmd_t                 dec;
  bank_op_t             op;
  logic                 par_bad, cmd_ok, any_open, es_c, et_c;
  logic [IDXW-1:0]      sel;
  logic [ADDRWIDTH-1:0] row_c;
  logic [TWIDTH-1:0]    trfc_cnt;
  logic [NBANK-1:0]     hit, tr_es, tr_et;
  logic [ADDRWIDTH-1:0] tr_row [NBANK];

  assign sel      = IDXW'(bank_index(32'(bg), 32'(ba), BAWIDTH));
  assign any_open = |bank_open;
  assign par_bad  = (PARITY_EN != 0) && cke && !cs_n && (^{act_n, A, bg, ba, parity});
  assign cmd_ok   = (dec != CMD_NOP) && !par_bad;

  always_comb begin
    dec = CMD_NOP;
    if (cke && !cs_n) begin
      if (!act_n) dec = CMD_ACT;
      else begin
        case (A[ADDRWIDTH-1 -: 3])
          RCW_RD:  dec = A[10] ? CMD_RDA  : CMD_RD;
          RCW_WR:  dec = A[10] ? CMD_WRA  : CMD_WR;
          RCW_PRE: dec = A[10] ? CMD_PREA : CMD_PRE;
          RCW_REF: dec = CMD_REF;
          RCW_MRS: dec = CMD_MRS;
          RCW_ZQC: dec = CMD_ZQC;
          default: dec = CMD_NOP;
        endcase
      end
    end
  end

  always_comb begin
    op = OP_NONE;
    if (cmd_ok) begin
      case (dec)
        CMD_ACT:           op = OP_ACT;
        CMD_RD, CMD_WR:    op = OP_RW;
        CMD_RDA:           op = OP_RDA;
        CMD_WRA:           op = OP_WRA;
        CMD_PRE, CMD_PREA: op = OP_PRE;
        default:           op = OP_NONE;
      endcase
    end
  end

  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    assign hit[i] = (dec == CMD_PREA) || (sel == IDXW'(i));
    ddr4_bank_tracker #(
      .ADDRWIDTH(ADDRWIDTH), .TWIDTH(TWIDTH), .T_RCD(T_RCD), .T_RP(T_RP),
      .T_RAS(T_RAS), .T_WR(T_WR), .T_RTP(T_RTP)
    ) u_bank (
      .ck_tp     (ck_tp),
      .reset     (reset),
      .op        (op),
      .hit       (hit[i]),
      .row_in    (A),
      .is_open   (bank_open[i]),
      .row       (tr_row[i]),
      .err_state (tr_es[i]),
      .err_timing(tr_et[i])
    );
  end

  // Column/precharge commands report the row they act on, taken from the tracker.
  always_comb begin
    row_c = '0;
    case (dec)
      CMD_ACT: row_c = A;
      CMD_RD, CMD_RDA, CMD_WR, CMD_WRA, CMD_PRE:
        row_c = bank_open[sel] ? tr_row[sel] : '0;
      default: row_c = '0;
    endcase
  end

  assign es_c = (|tr_es) | (cmd_ok && dec == CMD_REF && any_open);
  assign et_c = (|tr_et) | (cmd_ok && trfc_cnt != '0);

  always_ff @(posedge ck_tp or posedge reset) begin
    if (reset) begin
      trfc_cnt <= '0;
    end else if (cmd_ok && dec == CMD_REF && !any_open) begin
      trfc_cnt <= RFC_LD;
    end else if (trfc_cnt != '0) begin
      trfc_cnt <= trfc_cnt - TWIDTH'(1);
    end
  end

  always_ff @(posedge ck_tp or posedge reset) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      cmd        <= CMD_NOP;
      cmd_bg     <= '0;
      cmd_ba     <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      err_state  <= 1'b0;
      err_timing <= 1'b0;
      err_parity <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      cmd_valid  <= cmd_ok;
      err_state  <= es_c;
      err_timing <= et_c;
      err_parity <= par_bad;
      err_sticky <= err_sticky | es_c | et_c | par_bad;
      if (cmd_ok) begin
        cmd     <= dec;
        cmd_bg  <= bg;
        cmd_ba  <= ba;
        cmd_row <= row_c;
        cmd_col <= A[COLWIDTH-1:0];
      end
    end
  end

endmodule
